// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO read-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Bits needed to hold a counter that may reach max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] win,
  output logic [IDX_W-1:0] win_idx
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // Wrap by subtraction so non-power-of-two N_REQ works.
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
        win     = N_REQ'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter sharing the gray FIFO read port among N_REQ consumers,
// with bursts of up to BURST_MAX words per grant and a sticky read timeout.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic              rd_clk,
  input  logic              rst_,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              rd_req_,
  input  logic              empty,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] dout,
  output logic [N_REQ-1:0]  dout_vld,
  output logic              timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int BC_W  = cnt_width(BURST_MAX);
  localparam int WC_W  = cnt_width(TIMEOUT);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] w;
  logic [IDX_W-1:0] w_inc;
  logic [BC_W-1:0]  burst_cnt;
  logic [BC_W-1:0]  burst_inc;
  logic             burst_more;
  logic [WC_W-1:0]  wait_cnt;

  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;

  logic take_grant;
  logic release_gnt;
  logic word_in;
  logic do_timeout;
  logic clr_wait;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (pick),
    .win_idx (pick_idx)
  );

  assign burst_inc  = burst_cnt + BC_W'(1);
  assign burst_more = (burst_inc < BC_W'(BURST_MAX));
  assign w_inc      = (w == IDX_W'(N_REQ - 1)) ? '0 : (w + IDX_W'(1));

  always_comb begin
    state_nxt   = state;
    take_grant  = 1'b0;
    release_gnt = 1'b0;
    word_in     = 1'b0;
    do_timeout  = 1'b0;
    clr_wait    = 1'b0;
    rd_req_     = 1'b1;
    case (state)
      IDLE: begin
        if ((|req) && !empty) begin
          take_grant = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (!empty) begin
          rd_req_   = 1'b0;
          clr_wait  = 1'b1;
          state_nxt = WAIT;
        end else begin
          release_gnt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT: begin
        // A returning word wins over a timeout landing on the same cycle.
        if (rd_valid) begin
          word_in = 1'b1;
          if (req[w] && !empty && burst_more) begin
            state_nxt = ISSUE;
          end else begin
            release_gnt = 1'b1;
            state_nxt   = IDLE;
          end
        end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          do_timeout  = 1'b1;
          release_gnt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (!rst_) begin
      state       <= IDLE;
      gnt         <= '0;
      w           <= '0;
      rr_ptr      <= '0;
      burst_cnt   <= '0;
      wait_cnt    <= '0;
      dout        <= '0;
      dout_vld    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      dout_vld <= '0;
      if (take_grant) begin
        gnt       <= pick;
        w         <= pick_idx;
        burst_cnt <= '0;
      end
      if (release_gnt) begin
        gnt    <= '0;
        rr_ptr <= w_inc;
      end
      if (clr_wait) begin
        wait_cnt <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
      if (word_in) begin
        dout      <= rd_data;
        dout_vld  <= gnt;
        burst_cnt <= burst_inc;
      end
      if (do_timeout) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: per-cycle vector table plus FIFO-responder sequences.
module tb_fifo_rd_arbiter;

  logic       rd_clk = 1'b0;
  logic       rst_;
  logic [3:0] req;
  logic       empty;
  logic       rd_valid;
  logic [7:0] rd_data;

  logic [3:0] gnt_a, dout_vld_a, gnt_b, dout_vld_b;
  logic       rd_req_a, terr_a, rd_req_b, terr_b;
  logic [7:0] dout_a, dout_b;

  int checks = 0;
  int errors = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(4), .TIMEOUT(8)) u_dut (
    .rd_clk(rd_clk), .rst_(rst_), .req(req), .gnt(gnt_a), .rd_req_(rd_req_a),
    .empty(empty), .rd_valid(rd_valid), .rd_data(rd_data), .dout(dout_a),
    .dout_vld(dout_vld_a), .timeout_err(terr_a)
  );

  fifo_rd_arbiter #(.N_REQ(4), .DATA_W(8), .BURST_MAX(1), .TIMEOUT(8)) u_rr (
    .rd_clk(rd_clk), .rst_(rst_), .req(req), .gnt(gnt_b), .rd_req_(rd_req_b),
    .empty(empty), .rd_valid(rd_valid), .rd_data(rd_data), .dout(dout_b),
    .dout_vld(dout_vld_b), .timeout_err(terr_b)
  );

  typedef struct packed {
    logic       rst_;
    logic [3:0] req;
    logic       empty;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] gnt;
    logic       rd_req_;
    logic [3:0] dout_vld;
    logic [7:0] dout;
    logic       terr;
  } vec_t;

  vec_t vecs [32];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic e,
                              input logic v, input logic [7:0] dt, input logic [3:0] g,
                              input logic rr, input logic [3:0] dv, input logic [7:0] d,
                              input logic t);
    vec_t x;
    x.rst_ = r; x.req = rq; x.empty = e; x.rd_valid = v; x.rd_data = dt;
    x.gnt = g; x.rd_req_ = rr; x.dout_vld = dv; x.dout = d; x.terr = t;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge rd_clk); #1;
    rst_ = 1'b0; req = 4'h0; empty = 1'b1; rd_valid = 1'b0; rd_data = 8'h00;
    @(posedge rd_clk); #1;
    @(posedge rd_clk); #1;
    rst_ = 1'b1;
  endtask

  // Responder results
  logic [3:0] grant_log [8];
  int         pulse_log [8];
  int         n_grants;
  int         n_words;

  // Acts as the FIFO: a read request popped in one cycle returns data the next.
  task automatic run_fifo(input int sel, input logic [3:0] rq, input int words, input int ncyc);
    int         left;
    logic       pend;
    int         sent;
    logic [3:0] g, dv, prev_g, last_g;
    logic       rr;
    logic [7:0] d, exp_d;
    left = words; pend = 1'b0; sent = 0; prev_g = 4'h0; n_grants = 0; n_words = 0;
    for (int i = 0; i < 8; i++) begin
      grant_log[i] = 4'h0;
      pulse_log[i] = 0;
    end
    repeat (ncyc) begin
      @(posedge rd_clk); #1;
      req      = rq;
      empty    = (left == 0);
      rd_valid = pend;
      rd_data  = pend ? 8'(8'h40 + sent) : 8'h00;
      if (pend) sent++;
      pend = 1'b0;
      @(negedge rd_clk);
      g  = sel ? gnt_b      : gnt_a;
      rr = sel ? rd_req_b   : rd_req_a;
      dv = sel ? dout_vld_b : dout_vld_a;
      d  = sel ? dout_b     : dout_a;
      if (!rr) begin
        chk("rdreq_while_empty", {31'd0, empty}, 32'd0);
        if (left > 0) left--;
        pend = 1'b1;
      end
      if (g != 4'h0 && prev_g == 4'h0 && n_grants < 8) begin
        grant_log[n_grants] = g;
        n_grants++;
      end
      prev_g = g;
      if (dv != 4'h0) begin
        last_g = (n_grants > 0) ? grant_log[n_grants-1] : 4'h0;
        exp_d  = 8'(8'h40 + n_words);
        chk("seq_dout_vld", {28'd0, dv}, {28'd0, last_g});
        chk("seq_dout", {24'd0, d}, {24'd0, exp_d});
        if (n_grants > 0) pulse_log[n_grants-1]++;
        n_words++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              rst req    e  v  data   | gnt    rq dv     dout   terr
    vecs[0]  = mk(0, 4'hF, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h00, 0);
    vecs[1]  = mk(0, 4'hF, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h00, 0);
    vecs[2]  = mk(1, 4'h2, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h00, 0);
    vecs[3]  = mk(1, 4'h2, 0, 0, 8'h00, 4'h2, 0, 4'h0, 8'h00, 0);
    vecs[4]  = mk(1, 4'h0, 0, 1, 8'hA5, 4'h2, 1, 4'h0, 8'h00, 0);
    vecs[5]  = mk(1, 4'h0, 0, 0, 8'h00, 4'h0, 1, 4'h2, 8'hA5, 0);
    vecs[6]  = mk(1, 4'h0, 0, 1, 8'h3C, 4'h0, 1, 4'h0, 8'hA5, 0);
    vecs[7]  = mk(1, 4'h0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'hA5, 0);
    vecs[8]  = mk(1, 4'h1, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'hA5, 0);
    vecs[9]  = mk(1, 4'h1, 0, 0, 8'h00, 4'h1, 0, 4'h0, 8'hA5, 0);
    vecs[10] = mk(1, 4'h0, 0, 0, 8'h00, 4'h1, 1, 4'h0, 8'hA5, 0);
    vecs[11] = mk(1, 4'h0, 0, 1, 8'h5A, 4'h1, 1, 4'h0, 8'hA5, 0);
    vecs[12] = mk(1, 4'h0, 0, 0, 8'h00, 4'h0, 1, 4'h1, 8'h5A, 0);
    vecs[13] = mk(1, 4'h4, 1, 0, 8'h00, 4'h0, 1, 4'h0, 8'h5A, 0);
    vecs[14] = mk(1, 4'h4, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h5A, 0);
    vecs[15] = mk(1, 4'h4, 1, 0, 8'h00, 4'h4, 1, 4'h0, 8'h5A, 0);
    vecs[16] = mk(1, 4'h4, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h5A, 0);
    vecs[17] = mk(1, 4'h4, 0, 0, 8'h00, 4'h4, 0, 4'h0, 8'h5A, 0);
    for (int i = 18; i <= 25; i++)
      vecs[i] = mk(1, 4'h4, 0, 0, 8'h00, 4'h4, 1, 4'h0, 8'h5A, 0);
    vecs[26] = mk(1, 4'hC, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h5A, 1);
    vecs[27] = mk(1, 4'hC, 0, 0, 8'h00, 4'h8, 0, 4'h0, 8'h5A, 1);
    vecs[28] = mk(1, 4'hC, 0, 0, 8'h00, 4'h8, 1, 4'h0, 8'h5A, 1);
    vecs[29] = mk(0, 4'hC, 0, 0, 8'h00, 4'h8, 1, 4'h0, 8'h5A, 1);
    vecs[30] = mk(1, 4'h0, 0, 1, 8'hFF, 4'h0, 1, 4'h0, 8'h00, 0);
    vecs[31] = mk(1, 4'h0, 0, 0, 8'h00, 4'h0, 1, 4'h0, 8'h00, 0);

    rst_ = 1'b0; req = 4'hF; empty = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    @(posedge rd_clk);

    for (int i = 0; i < 32; i++) begin
      @(posedge rd_clk); #1;
      rst_     = vecs[i].rst_;
      req      = vecs[i].req;
      empty    = vecs[i].empty;
      rd_valid = vecs[i].rd_valid;
      rd_data  = vecs[i].rd_data;
      @(negedge rd_clk);
      chk($sformatf("vec%0d_gnt", i), {28'd0, gnt_a}, {28'd0, vecs[i].gnt});
      chk($sformatf("vec%0d_rd_req_", i), {31'd0, rd_req_a}, {31'd0, vecs[i].rd_req_});
      chk($sformatf("vec%0d_dout_vld", i), {28'd0, dout_vld_a}, {28'd0, vecs[i].dout_vld});
      chk($sformatf("vec%0d_dout", i), {24'd0, dout_a}, {24'd0, vecs[i].dout});
      chk($sformatf("vec%0d_timeout_err", i), {31'd0, terr_a}, {31'd0, vecs[i].terr});
    end

    // Burst cap: six words, BURST_MAX=4 -> 4 then 2 on a fresh grant.
    do_reset();
    run_fifo(0, 4'b0001, 6, 40);
    chk("burst_n_grants", n_grants, 2);
    chk("burst_grant0", {28'd0, grant_log[0]}, 32'h1);
    chk("burst_grant1", {28'd0, grant_log[1]}, 32'h1);
    chk("burst_pulses0", pulse_log[0], 4);
    chk("burst_pulses1", pulse_log[1], 2);
    chk("burst_words", n_words, 6);
    chk("burst_terr", {31'd0, terr_a}, 32'd0);

    // Empty rises after the second word: release after 2.
    do_reset();
    run_fifo(0, 4'b0001, 2, 20);
    chk("empty_n_grants", n_grants, 1);
    chk("empty_pulses0", pulse_log[0], 2);
    chk("empty_words", n_words, 2);
    chk("empty_gnt_idle", {28'd0, gnt_a}, 32'h0);

    // Round robin with BURST_MAX=1, all requesting.
    do_reset();
    run_fifo(1, 4'hF, 5, 40);
    chk("rr_n_grants", n_grants, 5);
    chk("rr_grant0", {28'd0, grant_log[0]}, 32'h1);
    chk("rr_grant1", {28'd0, grant_log[1]}, 32'h2);
    chk("rr_grant2", {28'd0, grant_log[2]}, 32'h4);
    chk("rr_grant3", {28'd0, grant_log[3]}, 32'h8);
    chk("rr_grant4", {28'd0, grant_log[4]}, 32'h1);
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_pulses%0d", i), pulse_log[i], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
